// File: rtl/tft_pattern_sched.sv
// Frame-synchronous test-pattern scheduler and RGB565 pixel source for the
// 480x272 TFT timing controller. The pattern changes only at frame starts
// (vsync rising edge), either automatically or by a host/key request. The
// pixel for a requested (pix_x, pix_y) is returned one clk_9m later.
module tft_pattern_sched #(
  parameter logic [7:0]  FRAMES_PER_PAT = 8'd60,
  parameter logic [9:0]  H_VALID        = 10'd480,
  parameter logic [9:0]  BAR_W          = 10'd60,
  parameter logic [15:0] SOLID_RGB      = 16'h001F
) (
  input  logic        clk_9m,
  input  logic        sys_rst,
  input  logic        vsync,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        auto_en,
  input  logic        sw_req,
  input  logic [1:0]  sw_mode,
  output logic        sw_busy,
  output logic        sw_ack,
  output logic [1:0]  cur_mode,
  output logic [15:0] pix_data
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  // A hold count of 0 behaves like 1: advance on every frame start.
  localparam logic [7:0] FPP_LAST = (FRAMES_PER_PAT == 8'd0) ? 8'd0 : FRAMES_PER_PAT - 8'd1;
  localparam logic [9:0] NO_REQ   = 10'h3FF;

  state_t      state_reg, state_next;
  logic [1:0]  cur_mode_reg, cur_mode_next;
  logic [1:0]  req_mode_reg, req_mode_next;
  logic [7:0]  frame_cnt_reg, frame_cnt_next;
  logic        vsync_d_reg;
  logic [15:0] pix_data_reg, pix_data_next;
  logic        frame_start;

  assign frame_start = vsync & ~vsync_d_reg;

  // State, mode, frame counter and vsync history registers.
  always_ff @(posedge clk_9m or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg     <= S_RUN;
      cur_mode_reg  <= 2'd0;
      req_mode_reg  <= 2'd0;
      frame_cnt_reg <= 8'd0;
      vsync_d_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_mode_reg  <= cur_mode_next;
      req_mode_reg  <= req_mode_next;
      frame_cnt_reg <= frame_cnt_next;
      vsync_d_reg   <= vsync;
    end
  end

  // Request handshake and auto-advance; a pending request blocks auto advance.
  always_comb begin
    state_next     = state_reg;
    cur_mode_next  = cur_mode_reg;
    req_mode_next  = req_mode_reg;
    frame_cnt_next = frame_cnt_reg;
    sw_busy        = 1'b0;
    sw_ack         = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (sw_req) begin
          req_mode_next = sw_mode;
          state_next    = S_PEND;
        end
        if (auto_en && frame_start) begin
          if (frame_cnt_reg == FPP_LAST) begin
            cur_mode_next  = cur_mode_reg + 2'd1;
            frame_cnt_next = 8'd0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      S_PEND: begin
        sw_busy = 1'b1;
        if (frame_start) begin
          state_next = S_APPLY;
        end
      end
      S_APPLY: begin
        sw_ack         = 1'b1;
        cur_mode_next  = req_mode_reg;
        frame_cnt_next = 8'd0;
        state_next     = S_RUN;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  // Colour-bar index from a thermometer of column thresholds (no divider).
  logic [6:0] bar_ge;
  logic [2:0] bar_idx;
  logic [15:0] bar_rgb;

  for (genvar gi = 0; gi < 7; gi++) begin : g_bar
    localparam logic [10:0] BAR_EDGE = 11'(BAR_W * (gi + 1));
    assign bar_ge[gi] = ({1'b0, pix_x} >= BAR_EDGE);
  end

  // Highest threshold crossed gives the bar number, then look up its colour.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (bar_ge[i]) begin
        bar_idx = 3'(i + 1);
      end
    end
    case (bar_idx)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  // Pattern mux; no request or columns past the active width give black.
  always_comb begin
    pix_data_next = 16'h0000;
    if ((pix_x != NO_REQ) && (pix_y != NO_REQ) && (pix_x < H_VALID)) begin
      case (cur_mode_reg)
        2'd0:    pix_data_next = bar_rgb;
        2'd1:    pix_data_next = {pix_x[8:4], pix_x[8:3], pix_x[8:4]};
        2'd2:    pix_data_next = (pix_x[5] ^ pix_y[5]) ? 16'hFFFF : 16'h0000;
        default: pix_data_next = SOLID_RGB;
      endcase
    end
  end

  // One-cycle pixel pipeline matching the controller's early request.
  always_ff @(posedge clk_9m or posedge sys_rst) begin
    if (sys_rst) begin
      pix_data_reg <= 16'h0000;
    end else begin
      pix_data_reg <= pix_data_next;
    end
  end

  assign cur_mode = cur_mode_reg;
  assign pix_data = pix_data_reg;

endmodule

// File: tb/tb_tft_pattern_sched.sv
// Directed bench for tft_pattern_sched. Pixel responses and sw_ack pulses
// are checked by monitor processes against expectation queues filled by the
// stimulus; mode/busy sequencing is checked inline.
module tb_tft_pattern_sched;

  logic        clk_9m = 1'b0;
  logic        sys_rst = 1'b1;
  logic        vsync = 1'b0;
  logic [9:0]  pix_x = 10'h3FF;
  logic [9:0]  pix_y = 10'h3FF;
  logic        auto_en = 1'b0;
  logic        sw_req = 1'b0;
  logic [1:0]  sw_mode = 2'd0;
  logic        sw_busy;
  logic        sw_ack;
  logic [1:0]  cur_mode;
  logic [15:0] pix_data;

  tft_pattern_sched #(
    .FRAMES_PER_PAT(8'd2),
    .H_VALID(10'd480),
    .BAR_W(10'd60),
    .SOLID_RGB(16'h001F)
  ) dut (
    .clk_9m(clk_9m),
    .sys_rst(sys_rst),
    .vsync(vsync),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .auto_en(auto_en),
    .sw_req(sw_req),
    .sw_mode(sw_mode),
    .sw_busy(sw_busy),
    .sw_ack(sw_ack),
    .cur_mode(cur_mode),
    .pix_data(pix_data)
  );

  always #5 clk_9m = ~clk_9m;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } pix_exp_t;

  pix_exp_t   pix_q[$];
  logic [1:0] ack_q[$];
  logic       pix_v = 1'b0;
  logic       pix_v_d = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       stop_mon = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s = %h", name, act);
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_9m);
    #1;
  endtask

  // Issue one pixel request and queue its expected response.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [15:0] exp, input string name);
    pix_exp_t e;
    e.name = $sformatf("%s(x=%0d,y=%0d)", name, x, y);
    e.exp  = exp;
    pix_q.push_back(e);
    pix_x = x;
    pix_y = y;
    pix_v = 1'b1;
    tick();
    pix_v = 1'b0;
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic request(input logic [1:0] mode, input bit expect_ack);
    sw_req  = 1'b1;
    sw_mode = mode;
    if (expect_ack) ack_q.push_back(mode);
    tick();
    sw_req = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 0;
    repeat (20) tick();
  endtask

  // Response valid for the pixel pipeline is the issue strobe delayed one cycle.
  always @(posedge clk_9m) pix_v_d <= pix_v;

  // Pixel monitor.
  initial begin
    while (!stop_mon) begin
      @(negedge clk_9m);
      if (pix_v_d) begin
        if (pix_q.size() == 0) begin
          check("pix_unexpected", pix_data, 16'hxxxx);
        end else begin
          pix_exp_t e;
          e = pix_q.pop_front();
          check(e.name, pix_data, e.exp);
        end
      end
    end
  end

  // Ack monitor: every pulse must be expected, and the new mode must show next cycle.
  initial begin
    logic [1:0] want;
    bit         pend;
    pend = 1'b0;
    want = 2'd0;
    while (!stop_mon) begin
      @(negedge clk_9m);
      if (pend) begin
        check("mode_after_ack", {14'd0, cur_mode}, {14'd0, want});
        pend = 1'b0;
      end
      if (sw_ack === 1'b1) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", {15'd0, sw_ack}, 16'd0);
        end else begin
          want = ack_q.pop_front();
          pend = 1'b1;
        end
      end
    end
  end

  int exp_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_cur_mode", {14'd0, cur_mode}, 16'd0);
    check("rst_sw_busy", {15'd0, sw_busy}, 16'd0);
    check("rst_sw_ack", {15'd0, sw_ack}, 16'd0);
    check("rst_pix_data", pix_data, 16'h0000);
    sys_rst = 1'b0;
    repeat (2) tick();

    // Mode 0 colour bars, bar edges and no-request / out-of-range columns.
    pix(10'd0,   10'd5, 16'hFFFF, "bar");
    pix(10'd59,  10'd5, 16'hFFFF, "bar");
    pix(10'd60,  10'd5, 16'hFFE0, "bar");
    pix(10'd200, 10'd5, 16'h07E0, "bar");
    pix(10'd359, 10'd5, 16'hF800, "bar");
    pix(10'd419, 10'd5, 16'h001F, "bar");
    pix(10'd420, 10'd5, 16'h0000, "bar");
    pix(10'd479, 10'd5, 16'h0000, "bar");
    pix(10'h3FF, 10'd5, 16'h0000, "bar_noreq_x");
    pix(10'd0, 10'h3FF, 16'h0000, "bar_noreq_y");
    pix(10'd500, 10'd5, 16'h0000, "bar_past_hvalid");

    // Manual switch to the checkerboard, busy until the next vsync rise.
    repeat (5) tick();
    request(2'd2, 1'b1);
    check("busy_after_req", {15'd0, sw_busy}, 16'd1);
    repeat (10) tick();
    check("busy_before_vsync", {15'd0, sw_busy}, 16'd1);
    check("mode_before_vsync", {14'd0, cur_mode}, 16'd0);
    frame();
    check("busy_after_apply", {15'd0, sw_busy}, 16'd0);
    check("mode_checker", {14'd0, cur_mode}, 16'd2);
    pix(10'd32, 10'd0,  16'hFFFF, "chk");
    pix(10'd32, 10'd32, 16'h0000, "chk");
    pix(10'd0,  10'd32, 16'hFFFF, "chk");
    pix(10'd480, 10'd0, 16'h0000, "chk_past_hvalid");

    // Horizontal ramp; 479 -> {11101,111011,11101} = EF7D from the bit formula.
    request(2'd1, 1'b1);
    frame();
    pix(10'd0,   10'd9, 16'h0000, "ramp");
    pix(10'd16,  10'd9, 16'h0841, "ramp");
    pix(10'd128, 10'd9, 16'h4208, "ramp");
    pix(10'd479, 10'd9, 16'hEF7D, "ramp");

    // Solid fill.
    request(2'd3, 1'b1);
    frame();
    pix(10'd100, 10'd100, 16'h001F, "solid");
    pix(10'd480, 10'd100, 16'h0000, "solid_past_hvalid");

    // Back to bars, then auto advance with a hold of two frames.
    request(2'd0, 1'b1);
    frame();
    auto_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("auto_mode_frame%0d", i), {14'd0, cur_mode}, 16'(exp_seq[i]));
      frame();
    end

    // Contention: auto is due this frame; first request (3) wins over the second (1).
    request(2'd3, 1'b1);
    repeat (5) tick();
    request(2'd1, 1'b0);
    check("contention_busy", {15'd0, sw_busy}, 16'd1);
    frame();
    check("contention_mode", {14'd0, cur_mode}, 16'd3);
    frame();
    check("cnt_cleared_hold", {14'd0, cur_mode}, 16'd3);
    frame();
    check("cnt_cleared_adv", {14'd0, cur_mode}, 16'd0);
    auto_en = 1'b0;

    // Request on the frame_start cycle applies at the following frame start.
    vsync = 1'b1;
    request(2'd2, 1'b1);
    repeat (2) tick();
    vsync = 1'b0;
    repeat (20) tick();
    check("samecyc_mode_held", {14'd0, cur_mode}, 16'd0);
    check("samecyc_busy", {15'd0, sw_busy}, 16'd1);
    frame();
    check("samecyc_mode_applied", {14'd0, cur_mode}, 16'd2);

    // Reset mid-frame with a request pending: no ack afterwards.
    request(2'd1, 1'b0);
    check("pre_rst_busy", {15'd0, sw_busy}, 16'd1);
    pix_x = 10'd32;
    pix_y = 10'd0;
    repeat (2) tick();
    check("pre_rst_pix", pix_data, 16'hFFFF);
    #3;
    sys_rst = 1'b1;
    #1;
    check("rst2_cur_mode", {14'd0, cur_mode}, 16'd0);
    check("rst2_sw_busy", {15'd0, sw_busy}, 16'd0);
    check("rst2_pix_data", pix_data, 16'h0000);
    repeat (2) tick();
    sys_rst = 1'b0;
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    frame();
    check("post_rst_mode", {14'd0, cur_mode}, 16'd0);
    check("post_rst_busy", {15'd0, sw_busy}, 16'd0);

    repeat (3) tick();
    check("ack_q_drained", 16'(ack_q.size()), 16'd0);
    check("pix_q_drained", 16'(pix_q.size()), 16'd0);
    stop_mon = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end

endmodule
